// File: rtl/nios_wallet_cpu_mult_unit_if.sv
// Issue/result bundle of the multiplier: operands and op in, product word out.
interface nios_wallet_cpu_mult_unit_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] E_src1;
  logic [DATA_W-1:0] E_src2;
  logic              E_valid;
  logic [1:0]        E_op;
  logic              M_en;
  logic              M_flush;
  logic [DATA_W-1:0] M_result;
  logic              M_result_valid;

  modport master (
    output E_src1, E_src2, E_valid, E_op, M_en, M_flush,
    input  M_result, M_result_valid
  );

  modport slave (
    input  E_src1, E_src2, E_valid, E_op, M_en, M_flush,
    output M_result, M_result_valid
  );
endinterface

// File: rtl/nios_wallet_cpu_mult_unit.sv
// Pipelined DATA_W x DATA_W multiplier built from four half-width partial products,
// returning the low word (MUL) or the signed/unsigned high word (MULX*).
module nios_wallet_cpu_mult_unit #(
  parameter int DATA_W      = 32,
  parameter int SLICE_W     = DATA_W / 2,
  parameter int PIPE_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  nios_wallet_cpu_mult_unit_if.slave   mbus
);
  localparam int PW = 2 * DATA_W;
  localparam int CW = DATA_W + 1;
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b11;

  // stage 1: partial products, sign correction, op, valid
  logic [DATA_W-1:0] pp_ll_q, pp_ll_d, pp_lh_q, pp_lh_d;
  logic [DATA_W-1:0] pp_hl_q, pp_hl_d, pp_hh_q, pp_hh_d;
  logic [CW-1:0]     corr_q, corr_d;
  logic [1:0]        op1_q, op1_d;
  logic              v1_q, v1_d;
  // stage 2: full product
  logic [PW-1:0]     prod_q, prod_d;
  logic [1:0]        op2_q, op2_d;
  logic              v2_q, v2_d;
  // stage 3: selected word
  logic [DATA_W-1:0] res_q, res_d;
  logic              v3_q, v3_d;

  logic [SLICE_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic               a_neg, b_neg;
  logic [PW-1:0]      sum_full;
  logic [PW-1:0]      prod_s2;
  logic [1:0]         op_s2;
  logic               v_s2;
  logic [DATA_W-1:0]  word_s3;
  logic               ld1, ld2, ld3;

  always_comb begin
    a_lo  = mbus.E_src1[SLICE_W-1:0];
    a_hi  = mbus.E_src1[DATA_W-1:SLICE_W];
    b_lo  = mbus.E_src2[SLICE_W-1:0];
    b_hi  = mbus.E_src2[DATA_W-1:SLICE_W];
    // A is signed for MULXSU/MULXSS, B only for MULXSS; a negative operand
    // contributes -(other operand) << DATA_W modulo 2^(2*DATA_W).
    a_neg = mbus.E_op[1] & mbus.E_src1[DATA_W-1];
    b_neg = (mbus.E_op == OP_MULXSS) & mbus.E_src2[DATA_W-1];

    sum_full = {pp_hh_q, pp_ll_q}
             + (PW'(pp_lh_q) << SLICE_W)
             + (PW'(pp_hl_q) << SLICE_W)
             - (PW'(corr_q) << DATA_W);

    prod_s2 = (PIPE_STAGES >= 2) ? prod_q : sum_full;
    op_s2   = (PIPE_STAGES >= 2) ? op2_q  : op1_q;
    v_s2    = (PIPE_STAGES >= 2) ? v2_q   : v1_q;
    word_s3 = (op_s2 == OP_MUL) ? prod_s2[DATA_W-1:0] : prod_s2[PW-1:DATA_W];

    // data only loads behind a valid token so the result word holds across bubbles
    ld1 = mbus.M_en & mbus.E_valid & ~mbus.M_flush;
    ld2 = mbus.M_en & v1_q & ~mbus.M_flush;
    ld3 = mbus.M_en & v_s2 & ~mbus.M_flush;

    pp_ll_d = pp_ll_q;
    pp_lh_d = pp_lh_q;
    pp_hl_d = pp_hl_q;
    pp_hh_d = pp_hh_q;
    corr_d  = corr_q;
    op1_d   = op1_q;
    prod_d  = prod_q;
    op2_d   = op2_q;
    res_d   = res_q;

    if (ld1) begin
      pp_ll_d = DATA_W'(a_lo) * DATA_W'(b_lo);
      pp_lh_d = DATA_W'(a_lo) * DATA_W'(b_hi);
      pp_hl_d = DATA_W'(a_hi) * DATA_W'(b_lo);
      pp_hh_d = DATA_W'(a_hi) * DATA_W'(b_hi);
      corr_d  = (a_neg ? CW'(mbus.E_src2) : CW'(0)) + (b_neg ? CW'(mbus.E_src1) : CW'(0));
      op1_d   = mbus.E_op;
    end
    if (ld2) begin
      prod_d = sum_full;
      op2_d  = op1_q;
    end
    if (ld3) begin
      res_d = word_s3;
    end

    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    if (mbus.M_flush) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
      v3_d = 1'b0;
    end else if (mbus.M_en) begin
      v1_d = mbus.E_valid;
      v2_d = v1_q;
      v3_d = v_s2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pp_ll_q <= '0;
      pp_lh_q <= '0;
      pp_hl_q <= '0;
      pp_hh_q <= '0;
      corr_q  <= '0;
      op1_q   <= '0;
      v1_q    <= 1'b0;
      prod_q  <= '0;
      op2_q   <= '0;
      v2_q    <= 1'b0;
      res_q   <= '0;
      v3_q    <= 1'b0;
    end else begin
      pp_ll_q <= pp_ll_d;
      pp_lh_q <= pp_lh_d;
      pp_hl_q <= pp_hl_d;
      pp_hh_q <= pp_hh_d;
      corr_q  <= corr_d;
      op1_q   <= op1_d;
      v1_q    <= v1_d;
      prod_q  <= prod_d;
      op2_q   <= op2_d;
      v2_q    <= v2_d;
      res_q   <= res_d;
      v3_q    <= v3_d;
    end
  end

  assign mbus.M_result       = (PIPE_STAGES >= 3) ? res_q : word_s3;
  assign mbus.M_result_valid = (PIPE_STAGES >= 3) ? v3_q  : v_s2;

endmodule

// File: tb/tb_nios_wallet_cpu_mult_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_nios_wallet_cpu_mult_unit;
  localparam int DW = 32;
  localparam int PS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_wallet_cpu_mult_unit_if #(.DATA_W(DW)) bus ();

  nios_wallet_cpu_mult_unit #(.DATA_W(DW), .SLICE_W(DW/2), .PIPE_STAGES(PS)) dut (
    .clk   (clk),
    .reset (reset),
    .mbus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [DW-1:0] val;
    int            rem;
  } ent_t;
  ent_t          inflight[$];
  logic          m_valid;
  logic [DW-1:0] m_result;

  function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [1:0] op);
    logic signed [DW:0]     ax;
    logic signed [DW:0]     bx;
    logic signed [2*DW+1:0] p;
    ax = op[1]       ? {a[DW-1], a} : {1'b0, a};
    bx = (op == 2'b11) ? {b[DW-1], b} : {1'b0, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[DW-1:0] : p[2*DW-1:DW];
  endfunction

  task automatic drive(input logic ev, input logic [1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic en, input logic fl);
    bus.E_valid = ev;
    bus.E_op    = op;
    bus.E_src1  = a;
    bus.E_src2  = b;
    bus.M_en    = en;
    bus.M_flush = fl;
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic tick();
    if (bus.M_flush) begin
      inflight.delete();
      m_valid = 1'b0;
    end else if (bus.M_en) begin
      if (bus.E_valid)
        inflight.push_back('{val: ref_mul(bus.E_src1, bus.E_src2, bus.E_op), rem: PS});
      foreach (inflight[i]) inflight[i].rem--;
      if (inflight.size() > 0 && inflight[0].rem == 0) begin
        m_valid  = 1'b1;
        m_result = inflight[0].val;
        void'(inflight.pop_front());
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    inflight.delete();
    m_valid  = 1'b0;
    m_result = '0;
    #12;
    n_cmp++;
    if (bus.M_result_valid !== 1'b0 || bus.M_result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%0b result=%h, want valid=0 result=00000000",
               bus.M_result_valid, bus.M_result);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.M_result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got valid=%0b, want 0", bus.M_result_valid);
    end
    $display("test_reset: done");
  endtask

  task automatic test_mul_words();
    drive(1'b1, 2'b00, 32'h0001_0003, 32'h0002_0005, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'b01, 32'h0001_0003, 32'h0002_0005, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (bus.M_result_valid !== 1'b1 || bus.M_result !== 32'h000B_000F) begin
      n_err++;
      $display("FAIL mul_low: got valid=%0b result=%h, want valid=1 result=000b000f",
               bus.M_result_valid, bus.M_result);
    end
    drive(1'b1, 2'b11, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (bus.M_result_valid !== 1'b1 || bus.M_result !== 32'h0000_0002) begin
      n_err++;
      $display("FAIL mulxuu_high: got valid=%0b result=%h, want valid=1 result=00000002",
               bus.M_result_valid, bus.M_result);
    end
    drive(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (bus.M_result_valid !== 1'b1 || bus.M_result !== 32'h4000_0000) begin
      n_err++;
      $display("FAIL mulxss_min: got valid=%0b result=%h, want valid=1 result=40000000",
               bus.M_result_valid, bus.M_result);
    end
    drive(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (bus.M_result_valid !== 1'b1 || bus.M_result !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL mul_min_wrap: got valid=%0b result=%h, want valid=1 result=00000000",
               bus.M_result_valid, bus.M_result);
    end
    tick();
    n_cmp++;
    if (bus.M_result_valid !== 1'b0 || bus.M_result !== 32'h0000_0000) begin
      n_err++;
      $display("FAIL bubble_hold: got valid=%0b result=%h, want valid=0 result=00000000",
               bus.M_result_valid, bus.M_result);
    end
    $display("test_mul_words: done");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_seq [3];
    exp_seq[0] = 32'hFFFF_FFFE;
    exp_seq[1] = 32'hFFFF_FFFF;
    exp_seq[2] = 32'h0000_0000;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(1'b1, 2'(k + 1), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      else       drive(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
      tick();
      if (k >= 1 && k <= 3) begin
        n_cmp++;
        if (bus.M_result_valid !== 1'b1 || bus.M_result !== exp_seq[k-1]) begin
          n_err++;
          $display("FAIL back_to_back[%0d]: got valid=%0b result=%h, want valid=1 result=%h",
                   k - 1, bus.M_result_valid, bus.M_result, exp_seq[k-1]);
        end
      end
    end
    $display("test_back_to_back: done");
  endtask

  task automatic test_stall();
    drive(1'b1, 2'b00, 32'd7, 32'd6, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
      tick();
      n_cmp++;
      if (bus.M_result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_no_valid[%0d]: got valid=%0b, want 0", k, bus.M_result_valid);
      end
    end
    drive(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.M_result_valid !== 1'b1 || bus.M_result !== 32'h0000_002A) begin
        n_err++;
        $display("FAIL stall_result[%0d]: got valid=%0b result=%h, want valid=1 result=0000002a",
                 k, bus.M_result_valid, bus.M_result);
      end
      drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0);
      tick();
    end
    $display("test_stall: done");
  endtask

  task automatic test_flush();
    drive(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'b00, 32'd3, 32'd5, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'b01, 32'hFFFF_0000, 32'h1234_5678, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'b11, 32'd9, 32'd9, 1'b1, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (bus.M_result_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_killed[%0d]: got valid=%0b, want 0", k, bus.M_result_valid);
      end
      drive(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
      tick();
    end
    $display("test_flush: done");
  endtask

  task automatic test_async_reset();
    drive(1'b1, 2'b00, 32'd11, 32'd13, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'b01, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b0);
    tick();
    drive(1'b1, 2'b00, 32'd2, 32'd2, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    inflight.delete();
    m_valid  = 1'b0;
    m_result = '0;
    #1;
    n_cmp++;
    if (bus.M_result_valid !== 1'b0 || bus.M_result !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%0b result=%h, want valid=0 result=00000000",
               bus.M_result_valid, bus.M_result);
    end
    #1;
    reset = 1'b0;
    drive(1'b0, 2'b00, '0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (bus.M_result_valid !== 1'b0 || bus.M_result !== 32'h0) begin
        n_err++;
        $display("FAIL post_reset_idle[%0d]: got valid=%0b result=%h, want valid=0 result=00000000",
                 k, bus.M_result_valid, bus.M_result);
      end
      tick();
    end
    $display("test_async_reset: done");
  endtask

  task automatic test_random();
    logic [DW-1:0] corners [4];
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    for (int k = 0; k < 400; k++) begin
      a = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 3)] : DW'($urandom);
      b = ($urandom_range(0, 5) == 0) ? corners[$urandom_range(0, 3)] : DW'($urandom);
      drive(1'($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), a, b,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
      n_cmp++;
      if (bus.M_result_valid !== m_valid || bus.M_result !== m_result) begin
        n_err++;
        $display("FAIL random[%0d]: got valid=%0b result=%h, want valid=%0b result=%h",
                 k, bus.M_result_valid, bus.M_result, m_valid, m_result);
      end else if (m_valid) begin
        $display("random[%0d]: result=%h", k, m_result);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_words();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios_wallet_cpu_mult_unit.md
NIOS_WALLET_CPU_MULT_UNIT -- requirements
Module: nios_wallet_cpu_mult_unit

Interface
REQ-001 Parameter DATA_W, default 32: operand and result width; SHALL be even and between 8 and 64.
REQ-002 Parameter SLICE_W, default DATA_W/2: partial-product slice width; SHALL equal DATA_W/2.
REQ-003 Parameter PIPE_STAGES, default 2: issue-to-result latency in enabled cycles; legal range 1..3.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 E_src1  in  DATA_W  operand A.
REQ-007 E_src2  in  DATA_W  operand B.
REQ-008 E_valid  in  1  operands and E_op are valid this cycle.
REQ-009 E_op  in  2  operation select: 00 MUL (low word), 01 MULXUU, 10 MULXSU (A signed, B unsigned), 11 MULXSS; 01, 10 and 11 return the high word.
REQ-010 M_en  in  1  pipeline advance enable.
REQ-011 M_flush  in  1  synchronous kill of all in-flight operations.
REQ-012 M_result  out  DATA_W  selected product word.
REQ-013 M_result_valid  out  1  M_result holds a completed operation.

Function
REQ-014 The block SHALL compute the exact 2*DATA_W-bit product of A and B, with each operand sign-extended or zero-extended per E_op, and return bits [DATA_W-1:0] for MUL or [2*DATA_W-1:DATA_W] otherwise.
REQ-015 The product SHALL be formed from four SLICE_W x SLICE_W unsigned partial products (lo*lo, lo*hi, hi*lo, hi*hi), plus sign-correction terms subtracted for signed operands.
REQ-016 Stage 1 SHALL register the partial products, the op and the valid bit. Stage 2 SHALL register the summed 2*DATA_W product. Stage 3 SHALL register the selected word.
REQ-017 When PIPE_STAGES is less than 3, the unused trailing stages SHALL be combinational, and latency SHALL equal PIPE_STAGES.
REQ-018 Each stage SHALL carry a valid bit. All stage registers, data and valid alike, SHALL load only when M_en=1, and SHALL hold otherwise.
REQ-019 An input SHALL enter stage 1 only in a cycle where E_valid=1 and M_en=1. When E_valid=0 and M_en=1, a bubble (valid=0) SHALL enter.
REQ-020 M_result_valid SHALL assert exactly PIPE_STAGES M_en-high cycles after acceptance, and SHALL remain asserted while M_en=0.
REQ-021 Back-to-back issue SHALL be supported; throughput SHALL be one result per M_en-high cycle.
REQ-022 M_flush=1 SHALL clear every stage valid bit at the next edge, regardless of M_en. Data registers SHALL be left unchanged.
REQ-023 When M_flush and E_valid&M_en occur in the same cycle, the flush SHALL win and the new operand SHALL be discarded.
REQ-024 When M_result_valid=0, M_result SHALL hold its last value; consumers SHALL ignore it.
REQ-025 No overflow indication SHALL be produced; the high word is exact and the low word wraps modulo 2^DATA_W.

Reset
REQ-026 Asserting reset SHALL immediately clear all valid bits, all data registers and M_result to 0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations; no result SHALL emerge after release.
REQ-028 The first operand SHALL be accepted on the first rising edge after reset deasserts, given E_valid=1 and M_en=1.

Verification (DATA_W=32, PIPE_STAGES=2, M_en=1 unless stated)
REQ-029 MUL, A=0x0001_0003, B=0x0002_0005 -> two cycles later M_result=0x000B_000F, M_result_valid=1. The same operands with MULXUU -> M_result=0x0000_0002.
REQ-030 A=B=0xFFFF_FFFF on consecutive cycles with MULXUU, MULXSU, MULXSS -> M_result=0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000 on three consecutive cycles.
REQ-031 MULXSS, A=B=0x8000_0000 -> M_result=0x4000_0000. MUL with the same operands -> M_result=0x0000_0000.
REQ-032 Stall: issue MUL 7*6, then drive M_en=0 for 3 cycles -> valid is not asserted during the stall. After M_en returns to 1 and the remaining stage completes, M_result=0x2A and M_result_valid=1, and both hold through any later M_en=0.
REQ-033 Flush: issue two back-to-back ops, then pulse M_flush together with a third E_valid -> M_result_valid stays 0 for all three ops.
REQ-034 Reset: assert reset between clock edges while two ops are in flight -> M_result=0 and M_result_valid=0 immediately. No valid output follows after release until a new op is issued.
